// File: rtl/max_pool_2d_if.sv
// Pixel stream and pooled result bus between a feature-map producer
// and the 2x2 max-pooling block.
interface max_pool_2d_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  i_start;
    logic [DATA_WIDTH-1:0] i_data;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  o_done;

    // Producer side: drives start/pixels, observes pooled results.
    modport master (
        output i_start, i_data,
        input  o_data, o_valid, o_done
    );

    // Pooling block side.
    modport slave (
        input  i_start, i_data,
        output o_data, o_valid, o_done
    );
endinterface

// File: rtl/max_pool_2d.sv
// Streaming 2x2 / stride-2 max pooling over one raster-order feature map.
// A horizontal pair register folds each pixel pair; even rows park the
// pair maximum in a half-width line buffer, odd rows combine it with the
// stored value of the row above and emit the window maximum.
module max_pool_2d #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 6,
    parameter int IMG_HEIGHT = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    max_pool_2d_if.slave bus
);
    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int ROW_W  = $clog2(IMG_HEIGHT);
    localparam int HALF_W = IMG_WIDTH / 2;
    localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_q;
    logic [DATA_WIDTH-1:0] pair_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] lbuf [HALF_W];

    logic                  running;
    logic                  last_px;
    logic [IDX_W-1:0]      lbuf_idx;
    logic [DATA_WIDTH-1:0] lbuf_rd;
    logic [DATA_WIDTH-1:0] pmax;
    logic [DATA_WIDTH-1:0] wmax;
    logic                  lbuf_we;

    assign running  = (state_q == RUN);
    assign last_px  = running && (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign lbuf_idx = IDX_W'(col_q >> 1);
    assign lbuf_rd  = lbuf[lbuf_idx];
    assign pmax     = (pair_q >= bus.i_data) ? pair_q : bus.i_data;
    assign wmax     = (pmax >= lbuf_rd) ? pmax : lbuf_rd;
    assign lbuf_we  = running && col_q[0] && !row_q[0];

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: frame sequencing IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.i_start) state_d = RUN;
            RUN:     if (last_px)     state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Raster counters, pair register and registered pooled outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= (state_q == DONE);
            if (running) begin
                if (!col_q[0]) begin
                    pair_q <= bus.i_data;
                end else if (row_q[0]) begin
                    data_q  <= wmax;
                    valid_q <= 1'b1;
                end
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // Line buffer holding the pair maxima of the most recent even row.
    always_ff @(posedge i_clk) begin
        // NOTE: no reset on the buffer; each entry is written on an even row
        // before the odd row reads it, so stale contents are never observed.
        if (lbuf_we) lbuf[lbuf_idx] <= pmax;
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_done  = done_q;
endmodule

// File: tb/tb_max_pool_2d.sv
// Self-checking bench for max_pool_2d: directed window table, the default
// ramp frame, mid-frame reset, start handling, back-to-back frames and
// randomized frames compared against a window-max reference model.
module tb_max_pool_2d;
    localparam int DW = 16;
    localparam int W  = 6;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int NR = (W / 2) * (H / 2);

    typedef logic [DW-1:0] px_t;
    typedef px_t frame_t [N];

    typedef struct {
        int  edge_n;
        px_t data;
    } result_t;

    typedef struct {
        px_t tl, tr, bl, br;
        px_t exp;
    } win_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   tests = 0;
    int   fails = 0;

    result_t got[$];
    int      dones[$];

    max_pool_2d_if #(.DATA_WIDTH(DW)) bus ();

    max_pool_2d #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Outputs reflect the most recent rising edge; record them mid-cycle.
    always @(negedge clk) begin
        if (bus.o_valid) got.push_back('{edge_cnt, bus.o_data});
        if (bus.o_done)  dones.push_back(edge_cnt);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: maximum over the 2x2 window at pooled position (r, c).
    function automatic px_t ref_pool(input frame_t f, input int r, input int c);
        px_t m = '0;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
                if (f[(2 * r + dy) * W + 2 * c + dx] > m) m = f[(2 * r + dy) * W + 2 * c + dx];
        return m;
    endfunction

    // Pulse start, stream a frame, then wait (bounded) for o_done.
    // glitch_k >= 0 raises i_start alongside pixel glitch_k.
    // rst_k >= 0 asserts reset instead of pixel rst_k and returns.
    task automatic run_frame(input frame_t f, input int glitch_k, input int rst_k,
                             input string tag, output int s);
        bit found;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        s = edge_cnt;
        for (int k = 0; k < N; k++) begin
            if (k == rst_k) begin
                rst = 1'b1;
                step();
                check({tag, " rst o_data"},  bus.o_data,  0);
                check({tag, " rst o_valid"}, bus.o_valid, 0);
                check({tag, " rst o_done"},  bus.o_done,  0);
                rst = 1'b0;
                bus.i_data = '0;
                return;
            end
            bus.i_data  = f[k];
            bus.i_start = (k == glitch_k);
            step();
        end
        bus.i_start = 1'b0;
        bus.i_data  = '0;
        found = 1'b0;
        for (int t = 0; t < 6; t++) begin
            step();
            if (bus.o_done) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, " done seen"}, found, 1);
        step();
    endtask

    // Consume one frame's results and done pulse, checking value and timing.
    task automatic check_frame(input frame_t f, input int s, input string tag);
        result_t e;
        int      d;
        check({tag, " result count"}, (got.size() >= NR), 1);
        for (int i = 0; i < NR; i++) begin
            if (got.size() == 0) break;
            e = got.pop_front();
            check($sformatf("%s data[%0d]", tag, i), e.data,
                  ref_pool(f, i / (W / 2), i % (W / 2)));
            check($sformatf("%s edge[%0d]", tag, i), e.edge_n - s,
                  1 + (2 * (i / (W / 2)) + 1) * W + 2 * (i % (W / 2)) + 1);
        end
        check({tag, " done count"}, (dones.size() >= 1), 1);
        if (dones.size() > 0) begin
            d = dones.pop_front();
            check({tag, " done edge"}, d - s, N + 1);
        end
    endtask

    task automatic check_drained(input string tag);
        check({tag, " no extra valid"}, got.size(), 0);
        check({tag, " no extra done"}, dones.size(), 0);
        got.delete();
        dones.delete();
    endtask

    initial begin
        frame_t   ramp, f, f2;
        win_vec_t vecs[NR];
        px_t      ramp_exp[NR];
        int       s, s2;
        result_t  e;

        vecs[0] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h1234};
        vecs[1] = '{16'h0000, 16'h5a5a, 16'h0000, 16'h0000, 16'h5a5a};
        vecs[2] = '{16'h0000, 16'h0000, 16'h00ff, 16'h0000, 16'h00ff};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 16'hbeef, 16'hbeef};
        vecs[4] = '{16'h4444, 16'h4444, 16'h4444, 16'h4444, 16'h4444};
        vecs[5] = '{16'h8000, 16'h7fff, 16'h0001, 16'h0000, 16'h8000};
        vecs[6] = '{16'hffff, 16'h0000, 16'h0000, 16'h0000, 16'hffff};
        vecs[7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[8] = '{16'h7ffe, 16'h0001, 16'h7fff, 16'h7fff, 16'h7fff};

        ramp_exp = '{16'hff00, 16'h0900, 16'h0b00, 16'h1300, 16'h1500,
                     16'h1700, 16'h1f00, 16'h2100, 16'h2300};
        for (int k = 0; k < N; k++) ramp[k] = px_t'((k % 256) << 8);
        ramp[0] = 16'hff00;

        bus.i_start = 1'b0;
        bus.i_data  = '0;

        // Reset state.
        rst = 1'b1;
        repeat (3) step();
        check("reset o_data",  bus.o_data,  0);
        check("reset o_valid", bus.o_valid, 0);
        check("reset o_done",  bus.o_done,  0);
        rst = 1'b0;
        step();

        // Reset and start together: reset must win, nothing runs.
        rst = 1'b1;
        bus.i_start = 1'b1;
        step();
        rst = 1'b0;
        bus.i_start = 1'b0;
        repeat (N + 8) step();
        check_drained("rst+start");

        // Default ramp frame against the hand-computed result list.
        run_frame(ramp, -1, -1, "ramp", s);
        check("ramp count exact", got.size(), NR);
        for (int i = 0; i < NR && i < got.size(); i++)
            check($sformatf("ramp const[%0d]", i), got[i].data, ramp_exp[i]);
        check_frame(ramp, s, "ramp");
        check_drained("ramp");

        // Directed window table: max position, ties, unsigned compare.
        f = '{default: '0};
        for (int w = 0; w < NR; w++) begin
            f[(2 * (w / 3)) * W + 2 * (w % 3)]         = vecs[w].tl;
            f[(2 * (w / 3)) * W + 2 * (w % 3) + 1]     = vecs[w].tr;
            f[(2 * (w / 3) + 1) * W + 2 * (w % 3)]     = vecs[w].bl;
            f[(2 * (w / 3) + 1) * W + 2 * (w % 3) + 1] = vecs[w].br;
        end
        run_frame(f, -1, -1, "table", s);
        check("table count", got.size(), NR);
        for (int w = 0; w < NR; w++) begin
            if (got.size() == 0) break;
            e = got.pop_front();
            check($sformatf("table win[%0d]", w), e.data, vecs[w].exp);
        end
        check("table done count", dones.size(), 1);
        got.delete();
        dones.delete();

        // Reset after 15 pixels: the 3 results already produced stay, nothing after.
        run_frame(ramp, -1, 15, "midrst", s);
        repeat (N + 8) step();
        check("midrst results before reset", got.size(), 3);
        check("midrst no done", dones.size(), 0);
        got.delete();
        dones.delete();
        run_frame(ramp, -1, -1, "after rst", s);
        check_frame(ramp, s, "after rst");
        check_drained("after rst");

        // Start pulse during RUN is ignored.
        run_frame(ramp, 10, -1, "glitch", s);
        check_frame(ramp, s, "glitch");
        check_drained("glitch");

        // Two frames back-to-back after o_done.
        for (int k = 0; k < N; k++) f[k] = px_t'($urandom);
        for (int k = 0; k < N; k++) f2[k] = px_t'($urandom);
        run_frame(f, -1, -1, "b2b A", s);
        run_frame(f2, -1, -1, "b2b B", s2);
        check("b2b total results", got.size(), 2 * NR);
        check("b2b total dones", dones.size(), 2);
        check_frame(f, s, "b2b A");
        check_frame(f2, s2, "b2b B");
        check_drained("b2b");

        // Randomized frames: full range, narrow range (ties), extremes.
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < N; k++) begin
                case (n % 3)
                    0:       f[k] = px_t'($urandom);
                    1:       f[k] = px_t'($urandom_range(0, 3));
                    default: f[k] = ($urandom_range(0, 1) != 0) ? px_t'(16'h8000 + $urandom_range(0, 2))
                                                               : px_t'(16'h7ffe + $urandom_range(0, 1));
                endcase
            end
            run_frame(f, -1, -1, $sformatf("rand%0d", n), s);
            check_frame(f, s, $sformatf("rand%0d", n));
            check_drained($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/max_pool_2d.md
# max_pool_2d

Streaming 2x2, stride-2 max-pooling block for the convolution accelerator datapath. It sits after a feature-map producer and takes one IMG_WIDTH x IMG_HEIGHT map in raster order, one pixel per clock, after a start pulse. It emits one maximum per non-overlapping 2x2 window, in raster order of the pooled map, then signals completion.

## Interface
- DATA_WIDTH, 16: pixel width in bits; values are unsigned.
- IMG_WIDTH, 6: input map width in pixels; even, ≥2.
- IMG_HEIGHT, 6: input map height in pixels; even, ≥2.

Ports:
- i_clk  input  1  sole clock; all logic on its rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_start  input  1  start pulse; sampled in IDLE only.
- i_data  input  DATA_WIDTH  input pixel; no qualifying valid; sampled every RUN cycle.
- o_data  output  DATA_WIDTH  pooled maximum; registered; holds last value between valids.
- o_valid  output  1  one-cycle pulse marking o_data as a new pooled result.
- o_done  output  1  one-cycle pulse after the final pooled result of a frame.

## Operation
- States are IDLE, RUN and DONE.
  - IDLE → RUN: on an edge with i_start=1.
  - RUN → DONE: on the edge that accepts pixel N-1, where N = IMG_WIDTH*IMG_HEIGHT.
  - DONE → IDLE: unconditionally after one cycle.
- In RUN, one pixel is accepted per edge. Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) advance in raster order. col wraps to 0 and row increments at IMG_WIDTH-1.
- Horizontal pair register: at even col, store the pixel. At odd col, form pmax = max(stored, pixel).
- Line buffer: IMG_WIDTH/2 entries of DATA_WIDTH.
  - Even row, odd col: write pmax to entry col/2.
  - Odd row, odd col: o_data ← max(pmax, buffer[col/2]) and o_valid ← 1.
- Comparisons are unsigned, full DATA_WIDTH. Ties yield the equal value; no arithmetic growth.
- Output count is (IMG_WIDTH/2)*(IMG_HEIGHT/2) per frame.
- i_start is ignored in RUN and DONE; no restart mid-frame.
- Reset (any state, including mid-frame):
  - Next state is IDLE.
  - Counters, pair register and o_data clear to 0.
  - o_valid and o_done clear to 0.
  - Line buffer contents need not clear; they are always written before being read.

## Timing
- Reset values: o_data=0, o_valid=0, o_done=0, state IDLE.
- Let edge S be the edge where i_start is sampled high in IDLE. Pixel k (k=0..N-1) is sampled on edge S+1+k.
- Latency: o_valid/o_data update on the edge that accepts the window's last pixel (odd row, odd col). They are visible in the following cycle.
- o_valid is high for exactly one cycle per result. Results for a pooled row are 2 cycles apart, and there are no results during even input rows.
- o_done goes high on edge S+N+1, one cycle after the cycle in which the final o_valid is visible. It stays high one cycle, then the block is in IDLE.
- A new i_start is accepted in the cycle after o_done falls.
- Frames are back-to-back capable with at most a 2-cycle gap (DONE plus IDLE sampling).
- Simultaneous i_rst and i_start: reset wins.

## Test plan
- Default 6x6 frame, pixel k = (k mod 256)<<8, pixel 0 = 0xff00, start pulse then 36 consecutive pixels:
  - o_valid pulses 9 times with o_data = ff00, 0900, 0b00, 1300, 1500, 1700, 1f00, 2100, 2300.
  - o_done pulses once, one cycle after the last valid.
- Cycle-level latency: check each o_valid appears exactly one cycle after the accepting edge of pixels 7, 9, 11, 19, 21, 23, 31, 33, 35. No o_valid is seen elsewhere.
- Max in each window position: place the maximum at top-left, top-right, bottom-left and bottom-right in successive windows (others 0). Each output equals the planted maximum. All-equal windows return that value.
- Unsigned compare: window {0x8000, 0x7fff, 0x0001, 0x0000} → 0x8000. Window {0xffff, 0, 0, 0} → 0xffff.
- Reset mid-frame: assert i_rst after 15 pixels.
  - Outputs go 0 next cycle, with no further o_valid or o_done.
  - A new full frame afterward produces correct 9 results.
- Start handling: pulse i_start during RUN → ignored, with output sequence unchanged. Two frames issued back-to-back after o_done → 18 correct results and 2 o_done pulses.
